// File: rtl/multimode_oscillator.sv
// multimode_oscillator: prescaled WIDTH-bit pattern walker (toggle/binary/gray/ring) with tick and wrap pulses
module multimode_oscillator #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 2,
    parameter int DIV_W = 8,
    parameter logic [WIDTH-1:0] RESET_STATE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [SEL_W-1:0] sel,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] state,
    output logic             tick,
    output logic             wrap
);
    logic [WIDTH-1:0] state_q, state_d, anchor_q, anchor_d;
    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [1:0]       mode_q, mode_d;
    logic             tick_q, tick_d, wrap_q, wrap_d;
    logic [WIDTH-1:0] bin, bin_inc, nxt;
    logic             adv, chg;
    always_comb begin
        for (int i = 0; i < WIDTH; i++) bin[i] = ^(state_q >> i);
        bin_inc = bin + 1'b1;
        // a shift of sel >= WIDTH clears the mask, so TOGGLE then holds state
        nxt = mode == 2'd0 ? state_q ^ ({{(WIDTH-1){1'b0}}, 1'b1} << sel) :
              mode == 2'd1 ? state_q + 1'b1 :
              mode == 2'd2 ? bin_inc ^ (bin_inc >> 1) :
                             {state_q[WIDTH-2:0], state_q[WIDTH-1]};
        adv      = en && pcnt_q == div;
        chg      = mode != mode_q || sel != sel_q;
        anchor_d = load ? load_val : chg ? state_q : anchor_q;
        state_d  = load ? load_val : adv ? nxt : state_q;
        pcnt_d   = load || adv ? '0 : en ? pcnt_q + 1'b1 : pcnt_q;
        tick_d   = !load && adv;
        wrap_d   = !load && adv && nxt == anchor_d;
        mode_d   = mode;
        sel_d    = sel;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RESET_STATE;
            anchor_q <= RESET_STATE;
            pcnt_q   <= '0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
            mode_q   <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            anchor_q <= anchor_d;
            pcnt_q   <= pcnt_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
        end
    end
    assign state = state_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;
endmodule

// File: tb/tb_multimode_oscillator.sv
// tb_multimode_oscillator: directed stimulus with a tick-driven scoreboard for multimode_oscillator
module tb_multimode_oscillator;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, load = 1'b0, tick, wrap;
    logic [3:0] load_val = '0, state;
    logic [1:0] sel = '0, mode = '0;
    logic [7:0] div = '0;
    int total = 0, bad = 0;
    logic [4:0] exp_q[$];

    multimode_oscillator dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .sel(sel),
        .mode(mode), .div(div), .state(state), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] st, input logic w);
        exp_q.push_back({w, st});
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // every tick must match the next queued {wrap,state}
    always @(negedge clk) begin
        if (rst && tick) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tick: got state=%b wrap=%b expected no tick", state, wrap);
            end else begin
                automatic logic [4:0] e = exp_q.pop_front();
                chk("tick_state_wrap", {wrap, state}, e);
            end
        end
    end

    initial begin
        automatic logic [3:0] g[16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                        4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        #2;
        chk("reset_state", {1'b0, state}, 5'b0);
        chk("reset_tick", {4'b0, tick}, 5'b0);
        chk("reset_wrap", {4'b0, wrap}, 5'b0);
        rst = 1'b1;
        cyc(5);
        chk("en0_hold", {tick, state}, 5'b0);
        // toggle bit 0, then switch to bit 1 with state 0001 as the new anchor
        en = 1'b1;
        push(4'b0001, 0); push(4'b0000, 1); push(4'b0001, 0); push(4'b0000, 1); push(4'b0001, 0);
        cyc(5);
        sel = 2'd1;
        push(4'b0011, 0); push(4'b0001, 1); push(4'b0011, 0); push(4'b0001, 1);
        cyc(4);
        // binary count with div=2 and a mid-count freeze
        mode = 2'd1; div = 8'd2; load = 1'b1; load_val = 4'b0000;
        cyc(1);
        load = 1'b0;
        for (int i = 1; i <= 5; i++) push(4'(i), 0);
        cyc(16);
        en = 1'b0;
        cyc(4);
        chk("freeze_state", {1'b0, state}, 5'b00101);
        en = 1'b1;
        push(4'd6, 0);
        cyc(1);
        chk("freeze_pcnt", {1'b0, state}, 5'b00101);
        cyc(1);
        for (int i = 7; i <= 15; i++) push(4'(i), 0);
        push(4'd0, 1);
        cyc(30);
        // gray count from 0000
        mode = 2'd2; div = 8'd0; load = 1'b1; load_val = 4'b0000;
        cyc(1);
        load = 1'b0;
        for (int i = 0; i < 16; i++) push(g[i], i == 15);
        cyc(16);
        // ring: load beats a coincident due advance
        mode = 2'd3; load = 1'b1; load_val = 4'b0001;
        cyc(1);
        load = 1'b0;
        chk("load_state", {1'b0, state}, 5'b00001);
        chk("load_no_tick", {4'b0, tick}, 5'b0);
        push(4'b0010, 0); push(4'b0100, 0); push(4'b1000, 0); push(4'b0001, 1);
        cyc(4);
        // async reset mid binary count at state 0110
        mode = 2'd1; div = 8'd2; load = 1'b1; load_val = 4'b0000;
        cyc(1);
        load = 1'b0;
        for (int i = 1; i <= 6; i++) push(4'(i), 0);
        cyc(18);
        #5;
        rst = 1'b0;
        #1;
        chk("async_rst_state", {1'b0, state}, 5'b0);
        chk("async_rst_tick", {4'b0, tick}, 5'b0);
        chk("async_rst_wrap", {4'b0, wrap}, 5'b0);
        #1;
        rst = 1'b1;
        cyc(2);
        chk("restart_spacing", {tick, state}, 5'b0);
        push(4'd1, 0);
        cyc(1);
        push(4'd2, 0); push(4'd3, 0);
        cyc(6);
        cyc(2);
        chk("scoreboard_drained", 5'(exp_q.size()), 5'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multimode_oscillator.md
Name: multimode_oscillator

Overview:
Parametrised successor to the team's 2-bit A-selected toggling oscillator FSM. Holds a WIDTH-bit state register that advances on every prescaled tick. Four selectable walk modes: single-bit toggle (bit chosen by sel), binary count, Gray count, and ring rotate. Adds enable, synchronous load, a programmable prescaler, and tick/wrap status pulses. Used as a pattern/test-sequence source and as a slow-strobe generator for other FSM blocks.

Parameters:
WIDTH, 4, state width in bits (>=2)
SEL_W, 2, width of sel; must satisfy 2**SEL_W >= WIDTH
DIV_W, 8, width of prescaler divisor
RESET_STATE, 0, state value applied on reset (WIDTH bits)

Ports:
clk  input  1  clock; all registers update on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  1 = prescaler runs and state may advance; 0 = freeze state and prescaler
load  input  1  synchronous load of load_val into state
load_val  input  WIDTH  value loaded when load=1
sel  input  SEL_W  bit index toggled in TOGGLE mode
mode  input  2  00 TOGGLE, 01 BINARY, 10 GRAY, 11 RING
div  input  DIV_W  prescaler divisor; state advances once per (div+1) enabled cycles
state  output  WIDTH  current state register
tick  output  1  registered pulse, high for the one cycle after a state advance
wrap  output  1  registered pulse, high the same cycle as tick when the new state equals anchor

Behaviour:
- Reset (rst=0, asynchronous): state=RESET_STATE, prescaler count=0, anchor=RESET_STATE, tick=0, wrap=0, mode_q/sel_q=0. Takes effect without a clock edge. The block leaves reset on the first clk edge after rst=1.
- Prescaler: internal count pcnt[DIV_W].
  - When en=1 and pcnt==div: an advance occurs and pcnt returns to 0.
  - When en=1 and pcnt!=div: pcnt increments.
  - en=0: pcnt holds.
  - div=0: an advance occurs on every enabled cycle.
  - div lowered below the current pcnt: pcnt counts up and wraps through 2**DIV_W before matching. No special handling.
- Next-state function on an advance, by mode:
  - TOGGLE: flip bit sel; all other bits hold. If sel>=WIDTH, state holds but tick still pulses. With WIDTH=2, sel=0/1 reproduces the 00-01 and 00-10 oscillations.
  - BINARY: state+1 modulo 2**WIDTH.
  - GRAY: bin=gray2bin(state); state = bin2gray(bin+1) modulo 2**WIDTH. A non-Gray starting value (e.g. from load) is treated as a Gray code word.
  - RING: rotate left by 1 (MSB wraps to bit 0). An all-zero state stays zero.
- Priority each edge: rst > load > advance > hold.
  - load=1: state=load_val, pcnt=0, anchor=load_val, tick=0, wrap=0, regardless of en or a coincident advance.
- tick: registered; 1 in the cycle after an advance edge, otherwise 0. It never stays high for two consecutive cycles unless div=0 and en=1 continuously.
- anchor: captured on reset, on load, and on any edge where mode!=mode_q or sel!=sel_q (anchor := current state). mode_q/sel_q are registered copies of mode/sel.
  - A mode or sel change takes effect on the next advance. No state change is caused by the switch itself.
- wrap: registered. Set on an advance edge whose next-state equals anchor. This gives period 2 in TOGGLE, 2**WIDTH in BINARY/GRAY, WIDTH in RING for a one-hot anchor, and every tick in RING for anchor 0.
- Latency: load_val is visible on state 1 cycle after load. First advance after load/reset occurs at the (div+1)th enabled edge.

Test Plan:
1. WIDTH=4, hold rst=0 with no clock edges → state=0000, tick=0, wrap=0 immediately. Release, en=0 for 5 cycles → state stays 0000, no tick.
2. mode=00, sel=0, div=0, en=1 → state 0000,0001,0000,0001, tick every cycle, wrap on every second tick. Switch sel=1 mid-run → next advances 0011/0001 alternation relative to the new anchor, wrap period 2.
3. mode=01, div=2 → state increments once per 3 cycles. 15 ticks reach 1111. The 16th tick gives 0000 with wrap=1. en=0 for 4 cycles mid-run freezes both pcnt and state.
4. mode=10 from 0000, div=0 → 0000,0001,0011,0010,0110,0111,0101,0100,1100…; exactly one bit changes per tick; wrap on the 16th tick.
5. mode=11, load=1 with load_val=0001 on the same edge as a due advance → state=0001, no tick. Then 0010,0100,1000,0001 with wrap on the 4th tick.
6. Assert rst=0 between clock edges mid-BINARY count (state=0110) → state=0000 and tick=0 asynchronously. The count restarts from 0000 after release with full div+1 spacing.
